// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
//   Shared definitions for the iterative MIPS DIV/DIVU unit: sequencer state
//   encoding and the default operand width.
// -----------------------------------------------------------------------------
package div_seq_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration on magnitudes.
//   Ports:
//     rem   in  WIDTH  partial remainder
//     quo   in  WIDTH  dividend/quotient shift register
//     div   in  WIDTH  divisor magnitude
//     rem_n out WIDTH  next partial remainder
//     quo_n out WIDTH  next quotient shift register
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    // Shifted remainder keeps its carry-out bit, so the compare is WIDTH+1 wide.
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, div};
    // rem_sh < 2*div always holds, so a non-negative difference fits in WIDTH
    // bits and the top bit of diff is a pure borrow flag.
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n  = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//   Multi-cycle iterative divider for DIV/DIVU in the EX stage. Accepts one
//   request, stalls the pipeline for WIDTH+1 cycles, then presents {HI,LO}
//   with validE for one cycle. annulE abandons a pending or in-flight divide.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     startE    in   divide present in EX (held while stalled)
//     signedE   in   1 = DIV, 0 = DIVU
//     opaE      in   dividend
//     opbE      in   divisor
//     annulE    in   flush of EX
//     stall_div out  stall request (combinational)
//     validE    out  result valid, DONE state only
//     hiE       out  remainder (registered)
//     loE       out  quotient (registered)
// -----------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] opaE,
  input  logic [WIDTH-1:0] opbE,
  input  logic             annulE,
  output logic             stall_div,
  output logic             validE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;
  logic             opa_neg;
  logic             opb_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_q),
    .quo   (quo_q),
    .div   (div_q),
    .rem_n (step_rem),
    .quo_n (step_quo)
  );

  always_comb begin
    accept  = startE & ~annulE;
    opa_neg = signedE & opaE[WIDTH-1];
    opb_neg = signedE & opbE[WIDTH-1];

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          // Work on magnitudes; the most negative value's magnitude is
          // still representable as an unsigned WIDTH-bit number.
          quo_d  = opa_neg ? -opaE : opaE;
          div_d  = opb_neg ? -opbE : opbE;
          rem_d  = '0;
          negq_d = opa_neg ^ opb_neg;
          negr_d = opa_neg;
          if (opbE == '0) begin
            hi_d    = opaE;
            lo_d    = '1;
            state_d = DIV_DONE;
          end else begin
            cnt_d   = CW'(WIDTH);
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration: sign-correct and register the result directly.
          lo_d    = negq_q ? -step_quo : step_quo;
          hi_d    = negr_q ? -step_rem : step_rem;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // startE may still be high here; it belongs to the finished divide.
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (annulE) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall_div = startE & ~annulE & (state_q != DIV_DONE);
  assign validE    = (state_q == DIV_DONE) & ~annulE;
  assign hiE       = hi_q;
  assign loE       = lo_q;

endmodule
